md_unit: RTL and testbench

//   Multiply/divide unit for the E stage. Sits beside the ALU and takes the

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_core.sv | 46 ++++
 rtl/md_unit.sv | 153 +++++++++++++++
 tb/tb_md_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit and its controller.
package md_pkg;

    // md_op encoding; every 3-bit value is a defined operation.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath: 64-bit product and quotient/remainder of the
// latched operands. Division uses magnitudes so that the most negative
// dividend over -1 wraps cleanly instead of overflowing.
module md_core
    import md_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        div0_o
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] uq;
    logic [31:0] ur;

    // Product, then sign/magnitude division with sign fix-up.
    always_comb begin
        sgn    = is_signed_op(md_op_e'(op_i));
        a_ext  = sgn ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
        b_ext  = sgn ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
        prod_o = a_ext * b_ext;

        a_neg  = sgn & a_i[31];
        b_neg  = sgn & b_i[31];
        a_mag  = a_neg ? -a_i : a_i;
        b_mag  = b_neg ? -b_i : b_i;
        div0_o = (b_i == '0);
        b_safe = div0_o ? 32'd1 : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        quot_o = (a_neg ^ b_neg) ? -uq : uq;
        rem_o  = a_neg ? -ur : ur;
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy counter and control.
// Results are computed from operands latched at issue and committed when
// the counter reaches its last cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    md_op_e             op_in;
    logic [63:0]        prod;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic               div0;

    assign op_in = md_op_e'(md_op);

    md_core u_core (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (prod),
        .quot_o (quot),
        .rem_o  (rem),
        .div0_o (div0)
    );

    // State, counter, latched operands and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Issue, countdown, commit and flush; flush outranks the final-cycle commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start && !flush) begin
                    case (op_in)
                        MD_MULT, MD_MULTU: begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            op_d    = op_in;
                            a_d     = md_a;
                            b_d     = md_b;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = op_in;
                            a_d     = md_a;
                            b_d     = md_b;
                        end
                        MD_MTHI: hi_d = md_a;
                        MD_MTLO: lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (is_mul(op_q)) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div0) begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Move-from read port; a same-cycle mthi/mtlo is not forwarded.
    always_comb begin
        md_out = '0;
        case (op_in)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = '0;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Hazard control must stall md ops while busy; such requests are dropped.
    always_ff @(posedge clk) begin
        if (reset_n && !flush) begin
            assert (!(md_start && state_q == ST_BUSY))
                else $warning("md_unit: md_start while busy ignored; hazard unit must stall");
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_md_unit;
    import md_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = MD_MFHI;
    logic [31:0] md_a = '0;
    logic [31:0] md_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md_start(md_start),
        .md_op   (md_op),
        .md_a    (md_a),
        .md_b    (md_b),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .md_out  (md_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        case (op)
            MD_MULT, MD_MULTU: return MULT_N;
            MD_DIV, MD_DIVU:   return DIV_N;
            default:           return 0;
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural definition.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            MD_MULT: begin
                p = sa * sb;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MD_MULTU: begin
                p = ua * ub;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MD_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                lo_m = q[31:0];
                hi_m = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            MD_MTHI: hi_m = a;
            MD_MTLO: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic check_mdout(input string tag);
        md_op = MD_MFHI;
        #1 chk({tag, ".mfhi"}, md_out, hi_m);
        md_op = MD_MFLO;
        #1 chk({tag, ".mflo"}, md_out, lo_m);
        md_op = MD_MULT;
        #1 chk({tag, ".other"}, md_out, 0);
        md_op = MD_MFHI;
    endtask

    // Issue one op at a negedge; count busy cycles (bounded), optionally
    // inject a stray md_start or a flush at a given busy cycle index.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at, input int flush_at);
        int   n;
        int   exp_n;
        logic flushed;
        md_op = op;
        md_a = a;
        md_b = b;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        md_op = MD_MFHI;
        n = 0;
        flushed = 1'b0;
        while (busy && n < 40) begin
            md_a = $urandom;
            md_b = $urandom;
            if (n == inject_at) begin
                md_start = 1'b1;
                md_op = MD_MTLO;
            end
            if (n == flush_at) begin
                flush = 1'b1;
                flushed = 1'b1;
            end
            @(negedge clk);
            md_start = 1'b0;
            flush = 1'b0;
            md_op = MD_MFHI;
            n++;
        end
        exp_n = (flush_at >= 0 && flush_at < lat(op)) ? flush_at + 1 : lat(op);
        chk({tag, ".busy_cycles"}, n, exp_n);
        if (!flushed) model(op, a, b);
        chk({tag, ".hi"}, hi, hi_m);
        chk({tag, ".lo"}, lo, lo_m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rf, ri;

        repeat (2) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.hi", hi, 0);
        chk("reset.lo", lo, 0);
        check_mdout("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, -1);
        chk("multu_max.hi_const", hi, 32'h1);
        chk("multu_max.lo_const", lo, 32'hFFFF_FFFE);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFF, 32'd3, -1, -1);
        chk("mult_neg.lo_const", lo, 32'hFFFF_FFFD);
        run_op("div_neg", MD_DIV, -32'sd7, 32'd2, -1, -1);
        chk("div_neg.lo_const", lo, 32'hFFFF_FFFD);
        chk("div_neg.hi_const", hi, 32'hFFFF_FFFF);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, -1, -1);
        run_op("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        chk("div_wrap.lo_const", lo, 32'h8000_0000);

        run_op("mthi", MD_MTHI, 32'h1234, 32'd0, -1, -1);
        check_mdout("mthi");

        run_op("div_stray_mtlo", MD_DIV, 32'd100, 32'd7, 4, -1);
        run_op("mult_flush3", MD_MULT, 32'd12345, 32'd6789, -1, 2);
        run_op("mult_flush_last", MD_MULTU, 32'hDEAD_BEEF, 32'h1111, -1, MULT_N - 1);
        run_op("div_flush_last", MD_DIVU, 32'hFFFF_0000, 32'd3, -1, DIV_N - 1);

        md_op = MD_MTHI;
        md_a = 32'hDEAD_0001;
        md_start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        flush = 1'b0;
        chk("flush_drops_start.hi", hi, hi_m);
        chk("flush_drops_start.busy", busy, 0);

        md_op = MD_DIV;
        md_a = 32'd1000;
        md_b = 32'd7;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.hi", hi, hi_m);
        chk("rst_mid.lo", lo, lo_m);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DIV_N) @(negedge clk);
        chk("rst_mid.no_commit_hi", hi, 0);
        chk("rst_mid.no_commit_lo", lo, 0);

        run_op("b2b_first", MD_MULT, 32'h0001_0000, 32'h0003_0000, -1, -1);
        run_op("b2b_second", MD_MULTU, 32'h7FFF_FFFF, 32'h0000_0011, -1, -1);

        for (int k = 0; k < 60; k++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
            ri = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
            run_op($sformatf("rand%0d", k), rop, ra, rb, ri, rf);
            if (k % 10 == 0) check_mdout($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
